inst_prefetch_queue: RTL and testbench

- Parametrised instruction-byte prefetch queue between the fetch unit and the prime decoder of the 6502 core.
- Fetch pushes one opcode/operand byte per cycle. Decode sees the oldest PULL_MAX bytes as a window and retires 1..PULL_MAX bytes per cycle, matching the decoded instruction length.
- A flush input empties the queue in one cycle on a taken branch, jump or interrupt.

---
 rtl/inst_prefetch_queue_if.sv | 48 ++++
 rtl/inst_prefetch_queue.sv | 101 ++++++++++
 tb/tb_inst_prefetch_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_prefetch_queue_if
// Bundles the fetch/decode side of the instruction prefetch queue.
//   queue_in        fetch byte to push
//   queue_push      push strobe
//   queue_pull      retire strobe
//   queue_pull_len  bytes to retire (0 = no-op)
//   queue_flush     discard all contents
//   queue_out       decode window, oldest byte in the low DATA_W bits
//   queue_valid     per-window-byte valid flags
//   queue_count     entries held
//   queue_full      count == DEPTH
//   queue_empty     count == 0
//   queue_overflow  one-cycle pulse: a push was dropped
//   queue_underflow one-cycle pulse: a pull was rejected
// master = fetch/decode side (drives requests), slave = the queue.
// ---------------------------------------------------------------------------
interface inst_prefetch_queue_if #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int PULL_MAX = 3,
  parameter int LEN_W    = 2
);
  logic [DATA_W-1:0]          queue_in;
  logic                       queue_push;
  logic                       queue_pull;
  logic [LEN_W-1:0]           queue_pull_len;
  logic                       queue_flush;
  logic [PULL_MAX*DATA_W-1:0] queue_out;
  logic [PULL_MAX-1:0]        queue_valid;
  logic [$clog2(DEPTH):0]     queue_count;
  logic                       queue_full;
  logic                       queue_empty;
  logic                       queue_overflow;
  logic                       queue_underflow;

  modport master (
    output queue_in, queue_push, queue_pull, queue_pull_len, queue_flush,
    input  queue_out, queue_valid, queue_count, queue_full, queue_empty,
           queue_overflow, queue_underflow
  );

  modport slave (
    input  queue_in, queue_push, queue_pull, queue_pull_len, queue_flush,
    output queue_out, queue_valid, queue_count, queue_full, queue_empty,
           queue_overflow, queue_underflow
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// inst_prefetch_queue
// Instruction-byte prefetch queue between fetch and the prime decoder.
// Fetch pushes one byte per cycle; decode sees the oldest PULL_MAX bytes as
// a window and retires 1..PULL_MAX of them per cycle. Flush empties the
// queue in one cycle.
// Ports:
//   queue_clk    rising-edge clock
//   queue_reset  asynchronous active-high reset
//   bus          slave side of inst_prefetch_queue_if (data, strobes, status)
// ---------------------------------------------------------------------------
module inst_prefetch_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int PULL_MAX = 3,
  parameter int LEN_W    = 2
) (
  input  logic                   queue_clk,
  input  logic                   queue_reset,
  inst_prefetch_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_push_ok;
  logic              w_push_drop;
  logic              w_pull_req;
  logic              w_pull_bad;
  logic              w_pull_ok;
  logic [CNT_W-1:0]  w_len_ext;
  logic [CNT_W-1:0]  w_count_next;
  logic [PULL_MAX-1:0] w_valid;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_len_ext = CNT_W'(bus.queue_pull_len);

  // Flush wins over everything, and suppresses error pulses too.
  assign w_push_ok   = bus.queue_push & ~w_full & ~bus.queue_flush;
  assign w_push_drop = bus.queue_push &  w_full & ~bus.queue_flush;

  // A zero-length pull is a silent no-op. Length is checked against the
  // current count only, so a byte pushed this cycle can never be retired.
  assign w_pull_req = bus.queue_pull & ~bus.queue_flush & (bus.queue_pull_len != '0);
  assign w_pull_bad = w_pull_req &
                      ((w_len_ext > CNT_W'(PULL_MAX)) | (w_len_ext > r_count));
  assign w_pull_ok  = w_pull_req & ~w_pull_bad;

  assign w_count_next = r_count + CNT_W'(w_push_ok) - (w_pull_ok ? w_len_ext : '0);

  always_ff @(posedge queue_clk or posedge queue_reset) begin
    if (queue_reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.queue_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pull_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(bus.queue_pull_len);
        r_count <= w_count_next;
      end
      r_overflow  <= w_push_drop;
      r_underflow <= w_pull_bad;
    end
  end

  // Storage carries no reset; the window masks stale entries via count.
  always_ff @(posedge queue_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= bus.queue_in;
  end

  // Window byte gi reads rd_ptr+gi; the pointer-width add wraps naturally,
  // so a window straddling DEPTH-1 -> 0 needs no special case.
  for (genvar gi = 0; gi < PULL_MAX; gi++) begin : g_window
    localparam logic [PTR_W-1:0] OFF = PTR_W'(gi);
    logic [PTR_W-1:0] w_idx;
    assign w_idx       = r_rd_ptr + OFF;
    assign w_valid[gi] = (r_count > CNT_W'(gi));
    assign bus.queue_out[gi*DATA_W +: DATA_W] = w_valid[gi] ? r_mem[w_idx] : '0;
  end

  assign bus.queue_valid     = w_valid;
  assign bus.queue_count     = r_count;
  assign bus.queue_full      = w_full;
  assign bus.queue_empty     = (r_count == '0);
  assign bus.queue_overflow  = r_overflow;
  assign bus.queue_underflow = r_underflow;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int PULL_MAX = 3;
  localparam int LEN_W    = 2;

  logic queue_clk = 1'b0;
  logic queue_reset;

  always #5 queue_clk = ~queue_clk;

  inst_prefetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PULL_MAX(PULL_MAX), .LEN_W(LEN_W)) bus ();

  inst_prefetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PULL_MAX(PULL_MAX), .LEN_W(LEN_W)) dut (
    .queue_clk   (queue_clk),
    .queue_reset (queue_reset),
    .bus         (bus)
  );

  typedef struct {
    string      tag;
    int         cnt;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string tag, string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tag, name, act, exp);
    end
  endfunction

  // Monitor: after every active edge, compare the DUT state with the
  // oldest expectation queued by the driver.
  always @(posedge queue_clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [2:0] v;
      e = sb.pop_front();
      v = {e.cnt > 2, e.cnt > 1, e.cnt > 0};
      check(e.tag, "count", 32'(bus.queue_count), 32'(e.cnt));
      check(e.tag, "window", 32'(bus.queue_out), {8'h00, e.b2, e.b1, e.b0});
      check(e.tag, "valid", 32'(bus.queue_valid), 32'(v));
      check(e.tag, "full", 32'(bus.queue_full), 32'(e.cnt == DEPTH));
      check(e.tag, "empty", 32'(bus.queue_empty), 32'(e.cnt == 0));
      check(e.tag, "ovf", 32'(bus.queue_overflow), 32'(e.ovf));
      check(e.tag, "unf", 32'(bus.queue_underflow), 32'(e.unf));
      $display("txn %-10s count=%0d out=%06h valid=%03b ovf=%0b unf=%0b",
               e.tag, bus.queue_count, bus.queue_out, bus.queue_valid,
               bus.queue_overflow, bus.queue_underflow);
    end
  end

  // One stimulus cycle: drive on the falling edge, queue what the state must
  // look like after the following rising edge.
  task automatic step(input string tag, input logic push, input logic [7:0] din,
                      input logic pull, input logic [1:0] len, input logic flush,
                      input int cnt, input logic [7:0] b2, input logic [7:0] b1,
                      input logic [7:0] b0, input logic ovf, input logic unf);
    exp_t e;
    @(negedge queue_clk);
    bus.queue_push     = push;
    bus.queue_in       = din;
    bus.queue_pull     = pull;
    bus.queue_pull_len = len;
    bus.queue_flush    = flush;
    e.tag = tag; e.cnt = cnt; e.b0 = b0; e.b1 = b1; e.b2 = b2; e.ovf = ovf; e.unf = unf;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.queue_in = '0; bus.queue_push = 0; bus.queue_pull = 0;
    bus.queue_pull_len = '0; bus.queue_flush = 0;
    queue_reset = 1'b1;
    #12;
    check("reset", "count", 32'(bus.queue_count), 0);
    check("reset", "empty", 32'(bus.queue_empty), 1);
    check("reset", "full", 32'(bus.queue_full), 0);
    check("reset", "valid", 32'(bus.queue_valid), 0);
    check("reset", "out", 32'(bus.queue_out), 0);
    check("reset", "ovf", 32'(bus.queue_overflow), 0);
    check("reset", "unf", 32'(bus.queue_underflow), 0);
    @(negedge queue_clk);
    queue_reset = 1'b0;

    // Fill 0x00..0x0F; window settles at 02,01,00.
    for (int k = 0; k < 16; k++)
      step("fill", 1, 8'(k), 0, 0, 0, k + 1,
           (k >= 2) ? 8'h02 : 8'h00, (k >= 1) ? 8'h01 : 8'h00, 8'h00, 0, 0);
    step("ovf",     1, 8'hAA, 0, 0, 0, 16, 8'h02, 8'h01, 8'h00, 1, 0);
    step("ovf_clr", 0, 8'h00, 0, 0, 0, 16, 8'h02, 8'h01, 8'h00, 0, 0);

    // Variable-length pulls 3, 1, 2.
    step("pull3", 0, 8'h00, 1, 3, 0, 13, 8'h05, 8'h04, 8'h03, 0, 0);
    step("pull1", 0, 8'h00, 1, 1, 0, 12, 8'h06, 8'h05, 8'h04, 0, 0);
    step("pull2", 0, 8'h00, 1, 2, 0, 10, 8'h08, 8'h07, 8'h06, 0, 0);

    // Refill to 16: 0x20..0x25 land in mem[0..5].
    for (int k = 0; k < 6; k++)
      step("refill", 1, 8'(8'h20 + k), 0, 0, 0, 11 + k, 8'h08, 8'h07, 8'h06, 0, 0);
    step("pull3b",  0, 8'h00, 1, 3, 0, 13, 8'h0B, 8'h0A, 8'h09, 0, 0);
    step("pushpull",1, 8'hB0, 1, 2, 0, 12, 8'h0D, 8'h0C, 8'h0B, 0, 0);
    // rd_ptr=14: window straddles the wrap (mem14, mem15, mem0).
    step("wrap",    0, 8'h00, 1, 3, 0,  9, 8'h20, 8'h0F, 8'h0E, 0, 0);
    step("postwrap",0, 8'h00, 1, 3, 0,  6, 8'h23, 8'h22, 8'h21, 0, 0);
    step("push_b1", 1, 8'hB1, 0, 0, 0,  7, 8'h23, 8'h22, 8'h21, 0, 0);

    // Flush beats same-cycle push and pull, no pulses.
    step("flush",   1, 8'hC1, 1, 1, 1,  0, 8'h00, 8'h00, 8'h00, 0, 0);
    step("push_c2", 1, 8'hC2, 0, 0, 0,  1, 8'h00, 8'h00, 8'hC2, 0, 0);
    step("push_c3", 1, 8'hC3, 0, 0, 0,  2, 8'h00, 8'hC3, 8'hC2, 0, 0);

    // Underflow and zero-length pull.
    step("underflow",0, 8'h00, 1, 3, 0, 2, 8'h00, 8'hC3, 8'hC2, 0, 1);
    step("unf_clr", 0, 8'h00, 0, 0, 0,  2, 8'h00, 8'hC3, 8'hC2, 0, 0);
    step("len0",    0, 8'h00, 1, 0, 0,  2, 8'h00, 8'hC3, 8'hC2, 0, 0);
    step("len0_chk",0, 8'h00, 0, 0, 0,  2, 8'h00, 8'hC3, 8'hC2, 0, 0);
    step("drain",   0, 8'h00, 1, 2, 0,  0, 8'h00, 8'h00, 8'h00, 0, 0);

    // Load five bytes, then reset between edges.
    for (int k = 0; k < 5; k++)
      step("load5", 1, 8'(8'hD0 + k), 0, 0, 0, k + 1,
           (k >= 2) ? 8'hD2 : 8'h00, (k >= 1) ? 8'hD1 : 8'h00, 8'hD0, 0, 0);
    @(posedge queue_clk);
    #3;
    queue_reset = 1'b1;
    #1;
    check("async_rst", "count", 32'(bus.queue_count), 0);
    check("async_rst", "empty", 32'(bus.queue_empty), 1);
    check("async_rst", "valid", 32'(bus.queue_valid), 0);
    check("async_rst", "out", 32'(bus.queue_out), 0);
    $display("txn async_rst  count=%0d out=%06h valid=%03b",
             bus.queue_count, bus.queue_out, bus.queue_valid);
    bus.queue_push = 0;
    @(negedge queue_clk);
    queue_reset = 1'b0;
    step("post_rst", 1, 8'hE0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hE0, 0, 0);
    step("idle",     0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00, 8'hE0, 0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge queue_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
